// File: rtl/counter_pkg.sv
// Shared types for the up/down modulus counter family.
package counter_pkg;

  localparam int unsigned MODE_W = 1;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

endpackage : counter_pkg

// File: rtl/counter_ud_step.sv
// Next-count computation for one enabled step of the modulus counter.
// Purely combinational; flags describe what the step would do if taken.
module counter_ud_step
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic [WIDTH-1:0] i_step,
  input  logic [WIDTH-1:0] i_max,
  input  logic             i_down,
  input  cnt_mode_e        i_mode,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap,
  output logic             o_sat
);

  localparam int unsigned XW = WIDTH + 1;

  logic [XW-1:0] w_cnt_x;
  logic [XW-1:0] w_max_x;
  logic [XW-1:0] w_mod;
  logic [XW-1:0] w_step_x;
  logic [XW-1:0] w_s;
  logic [XW-1:0] w_sum;
  logic [XW-1:0] w_sum_wrap;
  logic [XW-1:0] w_diff;
  logic [XW-1:0] w_diff_wrap;

  // Work one bit wider so max+1 and count+step never overflow.
  assign w_cnt_x     = XW'(i_count);
  assign w_max_x     = XW'(i_max);
  assign w_mod       = w_max_x + XW'(1);
  assign w_step_x    = XW'(i_step);
  assign w_s         = (w_step_x > w_mod) ? w_mod : w_step_x;
  assign w_sum       = w_cnt_x + w_s;
  assign w_sum_wrap  = w_sum - w_mod;
  assign w_diff      = w_cnt_x - w_s;
  assign w_diff_wrap = w_cnt_x + w_mod - w_s;

  always_comb begin
    o_next = i_count;
    o_wrap = 1'b0;
    o_sat  = 1'b0;
    if (w_s != '0) begin
      if (i_count > i_max) begin
        // Modulus was lowered under the count: pull back silently.
        o_next = i_max;
      end else if (!i_down) begin
        if (w_sum <= w_max_x) begin
          o_next = WIDTH'(w_sum);
        end else if (i_mode == MODE_WRAP) begin
          o_next = WIDTH'(w_sum_wrap);
          o_wrap = 1'b1;
        end else begin
          o_next = i_max;
          o_sat  = 1'b1;
        end
      end else begin
        if (w_s <= w_cnt_x) begin
          o_next = WIDTH'(w_diff);
        end else if (i_mode == MODE_WRAP) begin
          o_next = WIDTH'(w_diff_wrap);
          o_wrap = 1'b1;
        end else begin
          o_next = '0;
          o_sat  = 1'b1;
        end
      end
    end
  end

endmodule : counter_ud_step

// File: rtl/counter_ud_mod.sv
// Up/down counter with programmable modulus and step, wrap/saturate modes,
// clear/load priority and direction-correct terminal count for cascading.
module counter_ud_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_load_en,
  input  logic [WIDTH-1:0] i_load,
  input  logic             i_down,
  input  logic [WIDTH-1:0] i_step,
  input  logic [WIDTH-1:0] i_max,
  input  cnt_mode_e        i_mode,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_sat
);

  localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_sat;

  logic [WIDTH-1:0] w_next;
  logic             w_step_wrap;
  logic             w_step_sat;
  logic [WIDTH-1:0] w_load;

  counter_ud_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_count (r_count),
    .i_step  (i_step),
    .i_max   (i_max),
    .i_down  (i_down),
    .i_mode  (i_mode),
    .o_next  (w_next),
    .o_wrap  (w_step_wrap),
    .o_sat   (w_step_sat)
  );

  assign w_load = (i_load > i_max) ? i_max : i_load;

  // Priority: clear > load > enabled step > hold; flags only from a step.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_count <= CNT_RST;
      r_wrap  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_sat  <= 1'b0;
      if (i_clr) begin
        r_count <= CNT_RST;
      end else if (i_load_en) begin
        r_count <= w_load;
      end else if (i_en) begin
        r_count <= w_next;
        r_wrap  <= w_step_wrap;
        r_sat   <= w_step_sat;
      end
    end
  end

  assign o_count = r_count;
  assign o_wrap  = r_wrap;
  assign o_sat   = r_sat;
  assign o_tc    = i_en & ((~i_down & (r_count == i_max)) | (i_down & (r_count == '0)));

endmodule : counter_ud_mod

// File: tb/tb_counter_ud_mod.sv
// Directed self-checking bench for counter_ud_mod (WIDTH=4, RST_VAL=0).
module tb_counter_ud_mod;
  import counter_pkg::*;

  localparam int unsigned WIDTH = 4;

  logic             i_clk;
  logic             i_rstn;
  logic             i_en;
  logic             i_clr;
  logic             i_load_en;
  logic [WIDTH-1:0] i_load;
  logic             i_down;
  logic [WIDTH-1:0] i_step;
  logic [WIDTH-1:0] i_max;
  cnt_mode_e        i_mode;
  logic [WIDTH-1:0] o_count;
  logic             o_tc;
  logic             o_wrap;
  logic             o_sat;

  int n_checks;
  int n_errors;

  counter_ud_mod #(
    .WIDTH   (WIDTH),
    .RST_VAL (0)
  ) dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_en      (i_en),
    .i_clr     (i_clr),
    .i_load_en (i_load_en),
    .i_load    (i_load),
    .i_down    (i_down),
    .i_step    (i_step),
    .i_max     (i_max),
    .i_mode    (i_mode),
    .o_count   (o_count),
    .o_tc      (o_tc),
    .o_wrap    (o_wrap),
    .o_sat     (o_sat)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load_val(input logic [WIDTH-1:0] v);
    i_load_en = 1'b1;
    i_load    = v;
    i_en      = 1'b0;
    tick();
    i_load_en = 1'b0;
  endtask

  task automatic check_step(input string tag, input int cnt, input int wrp, input int sat);
    check({tag, "_cnt"}, 32'(o_count), 32'(cnt));
    check({tag, "_wrap"}, 32'(o_wrap), 32'(wrp));
    check({tag, "_sat"}, 32'(o_sat), 32'(sat));
  endtask

  int t2_cnt [4] = '{8, 5, 2, 9};
  int t2_wrp [4] = '{1, 0, 0, 1};

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    i_rstn    = 1'b0;
    i_en      = 1'b0;
    i_clr     = 1'b0;
    i_load_en = 1'b0;
    i_load    = '0;
    i_down    = 1'b0;
    i_step    = 4'd1;
    i_max     = 4'd9;
    i_mode    = MODE_WRAP;

    #12;
    check_step("rst", 0, 0, 0);
    check("rst_tc", 32'(o_tc), 32'd0);
    @(posedge i_clk);
    #1 i_rstn = 1'b1;
    tick();
    check_step("post_rst", 0, 0, 0);

    // Up by 1 modulo 10 across a wrap.
    i_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      check("t1_tc", 32'(o_tc), 32'((k - 1) % 10 == 9));
      tick();
      check_step("t1", k % 10, (k == 10) ? 1 : 0, 0);
    end

    // Down by 3 modulo 10 from 1, wrapping twice.
    load_val(4'd1);
    check("t2_load", 32'(o_count), 32'd1);
    i_down = 1'b1;
    i_step = 4'd3;
    i_en   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_step("t2", t2_cnt[k], t2_wrp[k], 0);
    end

    // Up saturate at 12, including the saturated hold.
    i_max  = 4'd12;
    i_mode = MODE_SAT;
    i_down = 1'b0;
    i_step = 4'd5;
    load_val(4'd10);
    i_en = 1'b1;
    tick();
    check_step("t3a", 12, 0, 1);
    check("t3_tc", 32'(o_tc), 32'd1);
    tick();
    check_step("t3b", 12, 0, 1);

    // Down saturate at 0, then terminal count in down direction.
    i_max  = 4'd9;
    i_down = 1'b1;
    i_step = 4'd3;
    load_val(4'd2);
    i_en = 1'b1;
    tick();
    check_step("t3c", 0, 0, 1);
    check("t3c_tc", 32'(o_tc), 32'd1);
    tick();
    check_step("t3d", 0, 0, 1);

    // Load clamp, clear beats load, clear beats a would-be wrap.
    i_down = 1'b0;
    i_mode = MODE_WRAP;
    i_step = 4'd1;
    load_val(4'd14);
    check_step("t4_clamp", 9, 0, 0);
    i_clr     = 1'b1;
    i_load_en = 1'b1;
    i_load    = 4'd5;
    tick();
    i_clr     = 1'b0;
    i_load_en = 1'b0;
    check_step("t4_clr_ld", 0, 0, 0);
    load_val(4'd9);
    i_en  = 1'b1;
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    check_step("t4_clr_wrap", 0, 0, 0);

    // Modulus lowered under the count pulls back without flags.
    load_val(4'd8);
    i_max = 4'd5;
    i_en  = 1'b1;
    tick();
    check_step("t5_pull", 5, 0, 0);

    // Oversized step clipped to the modulus: full lap, wrap flagged.
    i_max = 4'd3;
    load_val(4'd2);
    i_step = 4'd15;
    i_en   = 1'b1;
    tick();
    check_step("t5_bigstep", 2, 1, 0);

    // Asynchronous reset between edges, then zero step holds.
    i_max  = 4'd9;
    i_step = 4'd1;
    load_val(4'd6);
    i_en = 1'b1;
    tick();
    check("t6_pre", 32'(o_count), 32'd7);
    #2 i_rstn = 1'b0;
    #1;
    check_step("t6_async", 0, 0, 0);
    tick();
    check_step("t6_held", 0, 0, 0);
    i_rstn = 1'b1;
    i_step = 4'd0;
    tick();
    check_step("t6_zero_step", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_counter_ud_mod

// File: doc/counter_ud_mod.md
# counter_ud_mod

Parametrised up/down counter with a programmable modulus, a programmable step, wrap/saturate modes, count enable, synchronous clear and direction-correct terminal-count and event flags. It is the general-purpose successor to the plain up/down counter. Typical uses are timer prescalers, ring-pointer generators and cascaded counter chains.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥2)
- RST_VAL, 0, value of o_count after reset and after i_clr (must be ≤ any i_max used)

Ports:
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_en  in  1  count enable
- i_clr  in  1  synchronous clear to RST_VAL
- i_load_en  in  1  synchronous load strobe
- i_load  in  WIDTH  load value
- i_down  in  1  0 = count up, 1 = count down
- i_step  in  WIDTH  increment/decrement amount
- i_max  in  WIDTH  modulus minus one; the count range is 0..i_max
- i_mode  in  1  cnt_mode_e: 0 = MODE_WRAP, 1 = MODE_SAT
- o_count  out  WIDTH  current count, registered
- o_tc  out  1  terminal count, combinational
- o_wrap  out  1  one-cycle registered pulse: a wrap occurred
- o_sat  out  1  one-cycle registered pulse: a saturation clip occurred

## Operation
- Priority per edge: reset > i_clr > i_load_en > i_en count > hold. i_clr and i_load_en act regardless of i_en.
- Load: o_count <= min(i_load, i_max). No flags are raised.
- Effective step s = min(i_step, i_max+1), computed in WIDTH+1 bits. When s = 0, the count holds and no flags are raised.
- Out of range: if o_count > i_max on an enabled count cycle (i_max was lowered), o_count <= i_max. This applies in both modes and both directions, and no flags are raised.
- Up, sum = o_count + s in WIDTH+1 bits:
  - sum ≤ i_max: o_count <= sum
  - sum > i_max, WRAP: o_count <= sum − (i_max+1); o_wrap pulses
  - sum > i_max, SAT: o_count <= i_max; o_sat pulses
- Down:
  - s ≤ o_count: o_count <= o_count − s
  - s > o_count, WRAP: o_count <= o_count + i_max + 1 − s; o_wrap pulses
  - s > o_count, SAT: o_count <= 0; o_sat pulses
- Saturated hold: in SAT mode, when the count is already at the bound and a further step is attempted, the count is held and o_sat pulses again on each such cycle.
- o_tc = i_en & ((~i_down & o_count == i_max) | (i_down & o_count == 0)). Direction-correct; used as i_en of the next stage in a cascade.
- All arithmetic is unsigned.

## Timing
- Reset values: o_count = RST_VAL, o_wrap = 0, o_sat = 0. o_tc is combinational and follows the formula above.
- Reset is asynchronous on assertion. It must be released synchronously to i_clk, which is handled by an upstream synchronizer.
- Update latency: o_count reflects a clear, load or step on the edge that samples it, one cycle.
- o_wrap and o_sat assert in the same cycle as the new o_count and last exactly one cycle per event.
- Clear or load coinciding with a would-be wrap takes priority; no flag is raised.
- Reset mid-count: o_count, o_wrap and o_sat clear immediately, and counting resumes from RST_VAL on the first enabled edge after release.
- i_max, i_step and i_mode may change on any cycle and take effect on the next edge.

## Structure
- Package counter_pkg:
  - typedef enum logic {MODE_WRAP, MODE_SAT} cnt_mode_e
  - localparam MODE_W = 1
- Sub-module counter_ud_step: purely combinational. Inputs are count, step, max, down and mode. Outputs are next, wrap and sat.
- The top level holds the o_count, o_wrap and o_sat registers, the priority mux and o_tc.

## Test plan
- WIDTH=4, i_max=9, step 1, up, WRAP, 12 enables from 0: count 1..9, then 0, 1, 2. o_wrap pulses once on the 9→0 edge. o_tc=1 while count=9.
- i_max=9, step 3, down, WRAP, from 1: sequence 8, 5, 2, 9. o_wrap pulses on 1→8 and on 2→9.
- i_max=12, step 5, up, SAT, from 10: count 12, then 12 again. o_sat pulses on both edges.
- Load i_load=14 with i_max=9: count 9. i_clr and i_load_en asserted together with i_load=5: count RST_VAL.
- Count at 8, i_max lowered to 5, enable up: count 5, no flags. i_step=15 with i_max=3 up WRAP from 2: s=4, count 2, o_wrap pulses.
- Assert i_rstn low mid-count at 7 between edges: count 0 immediately, flags 0. After release, the first enable with i_step=0 leaves the count at 0 with no flags.
